// File: rtl/rt_get_server.sv
// rt_get_server: queues real-time request pulses, tracks each one's age, and
// returns a one-cycle response pulse when ctrl_grant releases the oldest one.
// A sticky error flags a request left waiting past DEADLINE cycles or a
// request arriving while the queue is full.
//
// Ports:
//   clk        - clock, all state updates on the rising edge
//   rst_n      - asynchronous active-low reset
//   rt_get     - request pulse, one request per high cycle
//   ctrl_grant - serves the oldest queued request when high
//   response   - registered one-cycle pulse per served request
//   pending    - registered count of queued requests (0..DEPTH)
//   busy       - pending != 0, combinational from state
//   error      - registered, sticky until reset
module rt_get_server #(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned CNT_W    = 3,
  parameter int unsigned DEADLINE = 5,
  parameter int unsigned AGE_W    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rt_get,
  input  logic             ctrl_grant,
  output logic             response,
  output logic [CNT_W-1:0] pending,
  output logic             busy,
  output logic             error
);

  // Queue storage: slot 0 is the oldest entry; valid slots are contiguous from 0.
  logic [DEPTH-1:0]             r_valid;
  logic [DEPTH-1:0][AGE_W-1:0]  r_age;
  logic [CNT_W-1:0]             r_pending;
  logic                         r_response;
  logic                         r_error;

  logic [DEPTH-1:0]             w_nxt_valid;
  logic [DEPTH-1:0][AGE_W-1:0]  w_nxt_age;
  logic [CNT_W-1:0]             w_nxt_pending;
  logic [CNT_W-1:0]             w_slot;
  logic                         w_pop;
  logic                         w_full;
  logic                         w_push;
  logic                         w_ovf;
  logic                         w_miss;

  // Edge events; a pop frees a slot for a push at the same edge.
  assign w_pop  = ctrl_grant & r_valid[0];
  assign w_full = (r_pending == CNT_W'(DEPTH));
  assign w_push = rt_get & (w_pop | ~w_full);
  assign w_ovf  = rt_get & ~w_pop & w_full;
  // Only the head can be the oldest, so only the head is deadline-checked.
  assign w_miss = ~w_pop & r_valid[0] & (r_age[0] == AGE_W'(DEADLINE - 1));
  // Append position is behind the entries that survive this edge.
  assign w_slot = r_pending - CNT_W'(w_pop);

  // Next queue contents: shift on pop, age survivors, then append.
  always_comb begin
    w_nxt_valid   = r_valid;
    w_nxt_age     = r_age;
    w_nxt_pending = r_pending;
    if (w_pop) begin
      w_nxt_valid = r_valid >> 1;
      w_nxt_age   = r_age >> AGE_W;
    end
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (w_nxt_valid[i] && (w_nxt_age[i] != AGE_W'(DEADLINE))) begin
        w_nxt_age[i] = w_nxt_age[i] + AGE_W'(1);
      end
    end
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (w_push && (w_slot == CNT_W'(i))) begin
        w_nxt_valid[i] = 1'b1;
        w_nxt_age[i]   = '0;
      end
    end
    w_nxt_pending = r_pending + CNT_W'(w_push) - CNT_W'(w_pop);
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid    <= '0;
      r_age      <= '0;
      r_pending  <= '0;
      r_response <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      r_valid    <= w_nxt_valid;
      r_age      <= w_nxt_age;
      r_pending  <= w_nxt_pending;
      r_response <= w_pop;
      r_error    <= r_error | w_ovf | w_miss;
    end
  end

  assign response = r_response;
  assign pending  = r_pending;
  assign busy     = (r_pending != '0);
  assign error    = r_error;

endmodule

// File: tb/tb_rt_get_server.sv
// Self-checking bench for rt_get_server: directed scenarios with literal
// expectations plus a randomized run, all compared every cycle against a
// queue-of-ages reference model.
module tb_rt_get_server;

  localparam int DEPTH    = 4;
  localparam int CNT_W    = 3;
  localparam int DEADLINE = 5;
  localparam int AGE_W    = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             rt_get = 1'b0;
  logic             ctrl_grant = 1'b0;
  logic             response;
  logic [CNT_W-1:0] pending;
  logic             busy;
  logic             error;

  rt_get_server #(
    .DEPTH(DEPTH), .CNT_W(CNT_W), .DEADLINE(DEADLINE), .AGE_W(AGE_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rt_get(rt_get), .ctrl_grant(ctrl_grant),
    .response(response), .pending(pending), .busy(busy), .error(error)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: ages of queued requests, oldest first.
  int q[$];
  bit m_err  = 1'b0;
  bit m_resp = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    q.delete();
    m_err  = 1'b0;
    m_resp = 1'b0;
  endfunction

  function automatic void model_edge(input bit g, input bit r);
    bit pop;
    pop = g && (q.size() > 0);
    m_resp = pop;
    if (pop) begin
      void'(q.pop_front());
    end else if (q.size() > 0 && q[0] == DEADLINE - 1) begin
      m_err = 1'b1;
    end
    foreach (q[i]) q[i] = (q[i] + 1 > DEADLINE) ? DEADLINE : q[i] + 1;
    if (r) begin
      if (q.size() < DEPTH) q.push_back(0);
      else m_err = 1'b1;
    end
  endfunction

  // Compare process: checks every output against the model each cycle.
  always @(negedge clk) begin
    chk("pending", int'(pending), q.size());
    chk("busy", int'(busy), int'(q.size() != 0));
    chk("response", int'(response), int'(m_resp));
    chk("error", int'(error), int'(m_err));
  end

  // Apply one edge's inputs; returns 1 time unit after the edge.
  task automatic step(input bit g, input bit r);
    ctrl_grant = g;
    rt_get     = r;
    @(posedge clk);
    if (rst_n) model_edge(g, r);
    #1;
    ctrl_grant = 1'b0;
    rt_get     = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic basic_service(input string tag);
    step(0, 1);
    chk({tag, "_pend1"}, int'(pending), 1);
    step(0, 0);
    step(0, 0);
    step(1, 0);
    chk({tag, "_resp"}, int'(response), 1);
    chk({tag, "_pend0"}, int'(pending), 0);
    step(0, 0);
    chk({tag, "_resp_end"}, int'(response), 0);
    chk({tag, "_err"}, int'(error), 0);
  endtask

  initial begin
    model_reset();
    do_reset();
    chk("rst_pend", int'(pending), 0);
    chk("rst_err", int'(error), 0);

    // Basic service: push E0, grant E3.
    basic_service("basic");

    // Deadline boundary: grant at E5 is safe.
    step(0, 1);
    repeat (4) step(0, 0);
    step(1, 0);
    chk("dl_ok_resp", int'(response), 1);
    chk("dl_ok_err", int'(error), 0);
    // Grant first at E6 misses the deadline.
    step(0, 1);
    repeat (4) step(0, 0);
    chk("dl_pre_err", int'(error), 0);
    step(0, 0);
    chk("dl_miss_err", int'(error), 1);
    step(1, 0);
    chk("dl_late_resp", int'(response), 1);
    step(0, 0);
    chk("dl_sticky", int'(error), 1);
    do_reset();

    // Ordering and overflow.
    repeat (4) step(0, 1);
    chk("ovf_full", int'(pending), 4);
    chk("ovf_pre_err", int'(error), 0);
    step(0, 1);
    chk("ovf_err", int'(error), 1);
    chk("ovf_pend", int'(pending), 4);
    for (int i = 0; i < 4; i++) begin
      step(1, 0);
      chk("ovf_pulse", int'(response), 1);
    end
    step(1, 0);
    chk("ovf_no_fifth", int'(response), 0);
    chk("ovf_empty", int'(pending), 0);
    do_reset();

    // Full with simultaneous push and pop.
    repeat (4) step(0, 1);
    step(1, 1);
    chk("fullpp_pend", int'(pending), 4);
    chk("fullpp_resp", int'(response), 1);
    chk("fullpp_err", int'(error), 0);
    step(0, 0);
    chk("fullpp_one", int'(response), 0);
    do_reset();

    // Empty grant and no bypass.
    for (int i = 0; i < 3; i++) begin
      step(1, 0);
      chk("empty_resp", int'(response), 0);
    end
    step(1, 1);
    chk("nobyp_pend", int'(pending), 1);
    chk("nobyp_resp", int'(response), 0);
    chk("nobyp_err", int'(error), 0);
    do_reset();

    // Asynchronous reset mid-cycle with pending = 3 and error = 1.
    repeat (4) step(0, 1);
    step(0, 1);
    step(1, 0);
    chk("ar_pre_pend", int'(pending), 3);
    chk("ar_pre_err", int'(error), 1);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("ar_pend", int'(pending), 0);
    chk("ar_busy", int'(busy), 0);
    chk("ar_resp", int'(response), 0);
    chk("ar_err", int'(error), 0);
    @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    basic_service("post_rst");

    // Randomized traffic with periodic resets.
    for (int n = 0; n < 3000; n++) begin
      if (n % 250 == 249) do_reset();
      step($urandom_range(0, 99) < 45, $urandom_range(0, 99) < 40);
    end

    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rt_get_server.md
# rt_get_server

Upstream/downstream companion to the real-time synthesis benchmarks. It consumes the benchmark's `_rt_get` request pulses, queues each one with an age counter, and returns a one-cycle `response` pulse when the controllable `ctrl_grant` input releases the oldest request. A sticky `error` flags any request left waiting past `DEADLINE` cycles and any queue overflow, so the synthesis tool must schedule `ctrl_grant` to keep `error` low.

## Interface
- `DEPTH`, 4: maximum number of outstanding requests (≥1).
- `CNT_W`, 3: width of `pending`; must hold the value DEPTH.
- `DEADLINE`, 5: maximum age, in cycles, that a queued request may reach without being served (≥1).
- `AGE_W`, 4: width of each age counter; must hold the value DEADLINE.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `rt_get` in 1: request from the benchmark (`_rt_get`); sampled every edge; one request per high cycle.
- `ctrl_grant` in 1: controllable input; when high, serves the oldest queued request.
- `response` out 1: registered one-cycle pulse per served request; feeds the benchmark's `response`.
- `pending` out CNT_W: number of queued requests (0..DEPTH).
- `busy` out 1: `pending != 0`; combinational from state.
- `error` out 1: registered and sticky.

## Operation
- Storage is an in-order queue of DEPTH entries. Each entry holds a valid bit and an AGE_W-bit age. Entry 0 is the oldest.
- Reset (rst_n low, asynchronous) clears the following, and they hold while rst_n is low:
  - all valid bits and ages to 0;
  - `response` = 0, `pending` = 0, `busy` = 0, `error` = 0.
- Pop: at an edge where `ctrl_grant` = 1 and `pending` > 0, entry 0 is removed and the remaining entries shift down one slot. `response` is 1 for the following cycle.
- `ctrl_grant` with an empty queue is ignored. It does not pulse `response` and does not raise `error`.
- Push: at an edge where `rt_get` = 1, a new entry with age 0 is appended behind the surviving entries.
  - There is no bypass. A request pushed at an edge cannot be popped at that same edge, even when the queue was empty.
- Simultaneous push and pop when full: the pop frees a slot and the push is accepted. `pending` stays at DEPTH and no error is raised.
- Overflow: `rt_get` = 1 while `pending` = DEPTH and no pop at that edge. The request is dropped and `error` is set.
- Aging: at every edge, each entry that is valid and not popped increments its age, saturating at DEADLINE.
- Deadline miss: at an edge where entry 0 has age DEADLINE-1 and is not popped, its age becomes DEADLINE and `error` is set.
  - Only the oldest entry is checked. Younger entries are never older than entry 0.
- `error` stays high until reset. The queue keeps operating normally after `error` is set.
- `pending` update per edge: +1 for an accepted push, −1 for a pop; both together leave it unchanged.

## Timing
- Request latency: a request pushed at edge E0 is safe if `ctrl_grant` is sampled high at any edge E1..E_DEADLINE while it is the oldest entry.
  - `response` is high during the cycle after the serving edge.
  - If not served by edge E_DEADLINE, `error` rises after E_DEADLINE.
- Back-to-back grants produce `response` high in consecutive cycles, one pulse per served request.
- `pending` and `busy` reflect the edge just taken; there are no extra pipeline stages.
- Reset asserted mid-operation discards all queued requests immediately. No `response` is produced for them after release.
- The first push after reset release is accepted at the first rising edge at which rst_n is high.

## Test plan
- Basic service (DEADLINE = 5): `rt_get` high at E0, `ctrl_grant` high at E3 → `response` = 1 for exactly one cycle after E3; `pending` goes 1 → 0; `error` = 0.
- Deadline boundary (DEADLINE = 5): push at E0 with grant at E5 → `error` stays 0. Push at E0 with grant first at E6 → `error` = 1 after E5, the response still pulses after E6, and `error` stays 1.
- Ordering and overflow (DEPTH = 4): push at E0..E3, giving `pending` = 4 → a fifth `rt_get` with no grant sets `error`, `pending` stays 4, and four later grants yield exactly four pulses.
- Full with simultaneous push/pop: with `pending` = 4, `rt_get` = 1 and `ctrl_grant` = 1 at the same edge → `pending` = 4, `response` pulses once, `error` = 0.
- Empty grant and no-bypass: `ctrl_grant` high at E0..E2 with an empty queue → no response. `rt_get` and `ctrl_grant` both high at the same edge with an empty queue → `pending` = 1, no response that cycle.
- Asynchronous reset: drop `rst_n` mid-cycle with `pending` = 3 and `error` = 1 → all outputs go to 0 immediately without a clock edge. After release, a new push/grant sequence behaves as in the basic-service scenario.
